// File: rtl/decoder_nto2n_seq_pkg.sv
// Shared definitions for the registered N-to-2^N decoder: FSM state and mode encodings.
package decoder_nto2n_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_PULSE = 2'd2
    } state_e;

    localparam logic MODE_HOLD  = 1'b0;
    localparam logic MODE_PULSE = 1'b1;

endpackage

// File: rtl/decoder_nto2n_seq_pulse_timer.sv
// Down-counter that times a one-shot pulse.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        load the counter with value (0 is loaded as 1)
//   value       pulse length in cycles
//   done        high while the counter holds 1 (the pulse's final cycle)
module decoder_nto2n_seq_pulse_timer #(
    parameter int unsigned PULSE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [PULSE_W-1:0] value,
    output logic               done
);

    logic [PULSE_W-1:0] cnt;

    // Counter stops at zero once the pulse has expired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (value == '0) ? PULSE_W'(1) : value;
        end else if (cnt != '0) begin
            cnt <= cnt - PULSE_W'(1);
        end
    end

    assign done = (cnt == PULSE_W'(1));

endmodule

// File: rtl/decoder_nto2n_seq.sv
// Registered binary-to-one-hot decoder with valid/ready input, enable,
// HOLD (level) or PULSE (timed one-shot) output mode and an out-of-range flag.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   in_valid    request valid
//   in_ready    request can be accepted (low only while a pulse runs)
//   sel         index to decode
//   en          1: drive the decoded line; 0: an accepted request clears y
//   mode        0: HOLD, 1: PULSE
//   pulse_len   pulse length in cycles (0 behaves as 1)
//   y           registered one-hot or zero output
//   out_valid   registered, equals (y != 0)
//   err         one-cycle flag for an accepted sel >= OUT_N
module decoder_nto2n_seq
    import decoder_nto2n_seq_pkg::*;
#(
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned OUT_N   = 4,
    parameter int unsigned PULSE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   sel,
    input  logic               en,
    input  logic               mode,
    input  logic [PULSE_W-1:0] pulse_len,
    output logic [OUT_N-1:0]   y,
    output logic               out_valid,
    output logic               err
);

    state_e           state;
    state_e           state_nxt;
    logic [OUT_N-1:0] y_nxt;
    logic             err_nxt;
    logic             load;
    logic             done;
    logic             accept;
    logic             out_of_range;
    logic [OUT_N-1:0] onehot;

    assign in_ready = (state != ST_PULSE);
    assign accept   = in_valid & in_ready;

    // Compare one bit wider so OUT_N == 2**SEL_W does not wrap to zero.
    assign out_of_range = ({1'b0, sel} >= (SEL_W + 1)'(OUT_N));
    assign onehot       = OUT_N'(1) << sel;

    decoder_nto2n_seq_pulse_timer #(
        .PULSE_W (PULSE_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .value (pulse_len),
        .done  (done)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            y         <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            y         <= y_nxt;
            out_valid <= (y_nxt != '0);
            err       <= err_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        y_nxt     = y;
        err_nxt   = 1'b0;
        load      = 1'b0;
        case (state)
            ST_IDLE, ST_HOLD: begin
                if (accept) begin
                    if (out_of_range) begin
                        // Bad index leaves the current output untouched.
                        err_nxt = 1'b1;
                    end else if (!en) begin
                        y_nxt     = '0;
                        state_nxt = ST_IDLE;
                    end else if (mode == MODE_HOLD) begin
                        y_nxt     = onehot;
                        state_nxt = ST_HOLD;
                    end else begin
                        y_nxt     = onehot;
                        state_nxt = ST_PULSE;
                        load      = 1'b1;
                    end
                end
            end
            ST_PULSE: begin
                if (done) begin
                    y_nxt     = '0;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                y_nxt     = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Self-checking bench: two decoders (OUT_N=4 and OUT_N=3) share one stimulus
// stream; each is compared against a cycle-level behavioural model.
module tb_decoder_nto2n_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] sel;
    logic       en;
    logic       mode;
    logic [3:0] pulse_len;

    logic       in_ready_a, out_valid_a, err_a;
    logic [3:0] y_a;
    logic       in_ready_b, out_valid_b, err_b;
    logic [2:0] y_b;

    always #5 clk = ~clk;

    decoder_nto2n_seq #(.SEL_W(2), .OUT_N(4), .PULSE_W(4)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_a),
        .sel       (sel),
        .en        (en),
        .mode      (mode),
        .pulse_len (pulse_len),
        .y         (y_a),
        .out_valid (out_valid_a),
        .err       (err_a)
    );

    decoder_nto2n_seq #(.SEL_W(2), .OUT_N(3), .PULSE_W(4)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_b),
        .sel       (sel),
        .en        (en),
        .mode      (mode),
        .pulse_len (pulse_len),
        .y         (y_b),
        .out_valid (out_valid_b),
        .err       (err_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: output value, pulse cycles still to run, error flag.
    int m_y   [2];
    int m_rem [2];
    int m_err [2];
    int m_n   [2] = '{4, 3};

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_y[i]   = 0;
            m_rem[i] = 0;
            m_err[i] = 0;
        end
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    function automatic void model_step();
        for (int i = 0; i < 2; i++) begin
            m_err[i] = 0;
            if (m_rem[i] > 0) begin
                m_rem[i]--;
                if (m_rem[i] == 0) m_y[i] = 0;
            end else if (in_valid) begin
                if (int'(sel) >= m_n[i]) begin
                    m_err[i] = 1;
                end else if (!en) begin
                    m_y[i] = 0;
                end else begin
                    m_y[i] = 1 << sel;
                    if (mode) m_rem[i] = (pulse_len == 4'd0) ? 1 : int'(pulse_len);
                end
            end
        end
    endfunction

    task automatic check_all();
        check_eq("y_a",         32'(y_a),         m_y[0]);
        check_eq("out_valid_a", 32'(out_valid_a), 32'(m_y[0] != 0));
        check_eq("err_a",       32'(err_a),       m_err[0]);
        check_eq("in_ready_a",  32'(in_ready_a),  32'(m_rem[0] == 0));
        check_eq("y_b",         32'(y_b),         m_y[1]);
        check_eq("out_valid_b", 32'(out_valid_b), 32'(m_y[1] != 0));
        check_eq("err_b",       32'(err_b),       m_err[1]);
        check_eq("in_ready_b",  32'(in_ready_b),  32'(m_rem[1] == 0));
    endtask

    // Drive one request at the falling edge, then check just after the rising edge.
    task automatic step(input logic v, input logic [1:0] s, input logic e,
                        input logic md, input logic [3:0] pl);
        @(negedge clk);
        in_valid  = v;
        sel       = s;
        en        = e;
        mode      = md;
        pulse_len = pl;
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        step(1'b0, 2'd0, 1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        sel       = 2'd3;
        en        = 1'b1;
        mode      = 1'b0;
        pulse_len = 4'd0;
        model_reset();

        // Reset holds everything idle even with a valid request present.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check_eq("rst_y",        32'(y_a),        32'h0);
            check_eq("rst_out_valid", 32'(out_valid_a), 32'h0);
            check_eq("rst_err",      32'(err_a),      32'h0);
            check_eq("rst_in_ready", 32'(in_ready_a), 32'h1);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // HOLD sweep, then disable.
        for (int s = 0; s < 4; s++) begin
            step(1'b1, 2'(s), 1'b1, 1'b0, 4'd0);
            check_eq("hold_sweep", 32'(y_a), 32'(1) << s);
        end
        step(1'b1, 2'd0, 1'b0, 1'b0, 4'd0);
        check_eq("hold_clear", 32'(y_a), 32'h0);

        // PULSE of 3 cycles; requests during the pulse are ignored.
        step(1'b1, 2'd2, 1'b1, 1'b1, 4'd3);
        for (int k = 0; k < 3; k++) begin
            check_eq("pulse3_y",     32'(y_a),        32'h4);
            check_eq("pulse3_ready", 32'(in_ready_a), 32'h0);
            if (k < 2) step(1'b1, 2'd1, 1'b1, 1'b0, 4'd0);
        end
        idle();
        check_eq("pulse3_end", 32'(y_a), 32'h0);
        check_eq("pulse3_rdy", 32'(in_ready_a), 32'h1);

        // pulse_len 0 behaves as 1.
        step(1'b1, 2'd2, 1'b1, 1'b1, 4'd0);
        check_eq("pulse0_y", 32'(y_a), 32'h4);
        idle();
        check_eq("pulse0_end", 32'(y_a), 32'h0);

        // Range error on the OUT_N=3 instance while holding 010.
        step(1'b1, 2'd1, 1'b1, 1'b0, 4'd0);
        check_eq("range_hold", 32'(y_b), 32'h2);
        step(1'b1, 2'd3, 1'b1, 1'b0, 4'd0);
        check_eq("range_err", 32'(err_b), 32'h1);
        check_eq("range_keep", 32'(y_b), 32'h2);
        check_eq("range_a_ok", 32'(err_a), 32'h0);
        idle();
        check_eq("range_err_1cyc", 32'(err_b), 32'h0);
        check_eq("range_keep2", 32'(y_b), 32'h2);
        step(1'b1, 2'd0, 1'b0, 1'b0, 4'd0);

        // Asynchronous reset in the middle of a long pulse.
        step(1'b1, 2'd2, 1'b1, 1'b1, 4'd10);
        for (int k = 0; k < 3; k++) idle();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("areset_y_a", 32'(y_a), 32'h0);
        check_eq("areset_ov_a", 32'(out_valid_a), 32'h0);
        check_eq("areset_y_b", 32'(y_b), 32'h0);
        check_eq("areset_rdy", 32'(in_ready_a), 32'h1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            idle();
            check_eq("areset_stays0", 32'(y_a), 32'h0);
        end

        // HOLD to PULSE switch with no zero gap.
        step(1'b1, 2'd1, 1'b1, 1'b0, 4'd0);
        check_eq("switch_hold", 32'(y_a), 32'h2);
        step(1'b1, 2'd3, 1'b1, 1'b1, 4'd2);
        check_eq("switch_pulse1", 32'(y_a), 32'h8);
        idle();
        check_eq("switch_pulse2", 32'(y_a), 32'h8);
        idle();
        check_eq("switch_end", 32'(y_a), 32'h0);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom_range(0, 4) != 0),
                 1'($urandom), 4'($urandom_range(0, 5)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
